// File: rtl/morse_decoder_pkg.sv
// Shared Morse definitions: FSM state encoding and the A-Z element table.
// Table entries are {len[2:0], code[3:0]}, code left-justified (first element in MSB), 1 = dash.
package morse_decoder_pkg;

  localparam int CODE_W      = 4;
  localparam int NUM_LETTERS = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_DECODE,
    ST_STUCK
  } state_t;

  function automatic logic [6:0] morse_entry(input logic [4:0] l);
    case (l)
      5'd1:    return {3'd2, 4'b0100};  // A .-
      5'd2:    return {3'd4, 4'b1000};  // B -...
      5'd3:    return {3'd4, 4'b1010};  // C -.-.
      5'd4:    return {3'd3, 4'b1000};  // D -..
      5'd5:    return {3'd1, 4'b0000};  // E .
      5'd6:    return {3'd4, 4'b0010};  // F ..-.
      5'd7:    return {3'd3, 4'b1100};  // G --.
      5'd8:    return {3'd4, 4'b0000};  // H ....
      5'd9:    return {3'd2, 4'b0000};  // I ..
      5'd10:   return {3'd4, 4'b0111};  // J .---
      5'd11:   return {3'd3, 4'b1010};  // K -.-
      5'd12:   return {3'd4, 4'b0100};  // L .-..
      5'd13:   return {3'd2, 4'b1100};  // M --
      5'd14:   return {3'd2, 4'b1000};  // N -.
      5'd15:   return {3'd3, 4'b1110};  // O ---
      5'd16:   return {3'd4, 4'b0110};  // P .--.
      5'd17:   return {3'd4, 4'b1101};  // Q --.-
      5'd18:   return {3'd3, 4'b0100};  // R .-.
      5'd19:   return {3'd3, 4'b0000};  // S ...
      5'd20:   return {3'd1, 4'b1000};  // T -
      5'd21:   return {3'd3, 4'b0010};  // U ..-
      5'd22:   return {3'd4, 4'b0001};  // V ...-
      5'd23:   return {3'd3, 4'b0110};  // W .--
      5'd24:   return {3'd4, 4'b1001};  // X -..-
      5'd25:   return {3'd4, 4'b1011};  // Y -.--
      5'd26:   return {3'd4, 4'b1100};  // Z --..
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational pattern lookup: {element count, left-justified code} -> letter 1..26.
module morse_lut
  import morse_decoder_pkg::*;
(
  input  logic [2:0]        len_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              hit_o,
  output logic [4:0]        letter_o
);

  always_comb begin
    hit_o    = 1'b0;
    letter_o = 5'd0;
    for (int i = 1; i <= NUM_LETTERS; i++) begin
      if ({len_i, code_i} == morse_entry(5'(i))) begin
        hit_o    = 1'b1;
        letter_o = 5'(i);
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse line decoder: times mark/space runs on the synchronised line, one letter per character.
// letter_valid/error are registered 1-cycle pulses; letter holds its last value. MAX_ELEM <= 4.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int DOT_TIME = 50000,
  parameter int MAX_ELEM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic [4:0] letter,
  output logic       letter_valid,
  output logic       error
);

  localparam int CW = $clog2(6*DOT_TIME+1);
  localparam logic [CW-1:0] RUN_ONE    = CW'(1);
  localparam logic [CW-1:0] GLITCH_LEN = CW'(DOT_TIME/2);
  localparam logic [CW-1:0] DASH_LEN   = CW'(2*DOT_TIME);
  localparam logic [CW-1:0] GAP_LEN    = CW'(2*DOT_TIME);
  localparam logic [CW-1:0] STUCK_LEN  = CW'(6*DOT_TIME);

  state_t            state_q, state_d;
  logic              sync1_q, in_s_q;
  logic [CW-1:0]     run_q, run_d;
  logic [CODE_W-1:0] code_q, code_d, code_lj;
  logic [2:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [4:0]        letter_q, letter_d, lut_letter;
  logic              vld_q, vld_d, err_q, err_d, lut_hit;

  // Elements were shifted in LSB-first; align the first one to the MSB for the table.
  assign code_lj = code_q << (3'(CODE_W) - cnt_q);

  morse_lut u_lut (
    .len_i    (cnt_q),
    .code_i   (code_lj),
    .hit_o    (lut_hit),
    .letter_o (lut_letter)
  );

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    letter_d = letter_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_s_q) begin
          state_d = ST_MARK;
          run_d   = RUN_ONE;
        end
      end
      ST_MARK: begin
        if (in_s_q) begin
          if (run_q >= STUCK_LEN - RUN_ONE) begin
            err_d   = 1'b1;
            state_d = ST_STUCK;
            run_d   = STUCK_LEN;
            code_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            run_d = run_q + RUN_ONE;
          end
        end else if (run_q < GLITCH_LEN) begin
          state_d = (cnt_q == 3'd0) ? ST_IDLE : ST_SPACE;
          run_d   = (cnt_q == 3'd0) ? '0 : RUN_ONE;
        end else begin
          if (cnt_q == 3'(MAX_ELEM)) begin
            ovf_d = 1'b1;
          end else begin
            code_d = {code_q[CODE_W-2:0], (run_q >= DASH_LEN)};
            cnt_d  = cnt_q + 3'd1;
          end
          state_d = ST_SPACE;
          run_d   = RUN_ONE;
        end
      end
      ST_SPACE: begin
        if (in_s_q) begin
          state_d = ST_MARK;
          run_d   = RUN_ONE;
        end else if (run_q >= GAP_LEN - RUN_ONE) begin
          state_d = ST_DECODE;
          run_d   = GAP_LEN;
        end else begin
          run_d = run_q + RUN_ONE;
        end
      end
      ST_DECODE: begin
        if (ovf_q || !lut_hit) begin
          err_d = 1'b1;
        end else begin
          letter_d = lut_letter;
          vld_d    = 1'b1;
        end
        code_d  = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = in_s_q ? ST_MARK : ST_IDLE;
        run_d   = in_s_q ? RUN_ONE : '0;
      end
      ST_STUCK: begin
        if (!in_s_q) begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      in_s_q   <= 1'b0;
      state_q  <= ST_IDLE;
      run_q    <= '0;
      code_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      letter_q <= 5'd0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= in;
      in_s_q   <= sync1_q;
      state_q  <= state_d;
      run_q    <= run_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      letter_q <= letter_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = vld_q;
  assign error        = err_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder at DOT_TIME=4: table of keyed patterns plus hand-written corner cases.
module tb_morse_decoder;

  logic       clk;
  logic       rst;
  logic       in;
  logic [4:0] letter;
  logic       letter_valid;
  logic       error;

  morse_decoder #(.DOT_TIME(4), .MAX_ELEM(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .letter       (letter),
    .letter_valid (letter_valid),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_chk  = 0;
  int  n_pass = 0;
  int  vld_cnt = 0;
  int  err_cnt = 0;
  int  both_cnt = 0;
  time t_vld = 0;
  time t_err = 0;

  always @(negedge clk) begin
    if (letter_valid) begin
      vld_cnt++;
      t_vld = $time;
    end
    if (error) begin
      err_cnt++;
      t_err = $time;
    end
    if (letter_valid && error) both_cnt++;
  end

  typedef struct {
    string pat;
    int    exp_vld;
    int    exp_err;
    int    exp_letter;
  } vec_t;

  vec_t vec[29];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic key(input logic level, input int n);
    in = level;
    repeat (n) @(negedge clk);
  endtask

  // Keys a pattern at one unit = 4 cycles: dot 1 unit, dash 3, element gap 1, trailing gap 4.
  task automatic send(input string p);
    byte ch;
    for (int i = 0; i < p.len(); i++) begin
      ch = p[i];
      key(1'b1, (ch == 8'h2D) ? 12 : 4);
      key(1'b0, (i == p.len() - 1) ? 16 : 4);
    end
  endtask

  initial begin
    int  v0, e0;
    time t0;

    vec[0]  = '{".-",   1, 0, 1};   vec[1]  = '{"-...", 1, 0, 2};
    vec[2]  = '{"-.-.", 1, 0, 3};   vec[3]  = '{"-..",  1, 0, 4};
    vec[4]  = '{".",    1, 0, 5};   vec[5]  = '{"..-.", 1, 0, 6};
    vec[6]  = '{"--.",  1, 0, 7};   vec[7]  = '{"....", 1, 0, 8};
    vec[8]  = '{"..",   1, 0, 9};   vec[9]  = '{".---", 1, 0, 10};
    vec[10] = '{"-.-",  1, 0, 11};  vec[11] = '{".-..", 1, 0, 12};
    vec[12] = '{"--",   1, 0, 13};  vec[13] = '{"-.",   1, 0, 14};
    vec[14] = '{"---",  1, 0, 15};  vec[15] = '{".--.", 1, 0, 16};
    vec[16] = '{"--.-", 1, 0, 17};  vec[17] = '{".-.",  1, 0, 18};
    vec[18] = '{"...",  1, 0, 19};  vec[19] = '{"-",    1, 0, 20};
    vec[20] = '{"..-",  1, 0, 21};  vec[21] = '{"...-", 1, 0, 22};
    vec[22] = '{".--",  1, 0, 23};  vec[23] = '{"-..-", 1, 0, 24};
    vec[24] = '{"-.--", 1, 0, 25};  vec[25] = '{"--..", 1, 0, 26};
    vec[26] = '{".....", 0, 1, 26};
    vec[27] = '{"..--", 0, 1, 26};
    vec[28] = '{"---.", 0, 1, 26};

    rst = 1'b1;
    in  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset letter", int'(letter), 0);
    check("reset letter_valid", int'(letter_valid), 0);
    check("reset error", int'(error), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 29; i++) begin
      v0 = vld_cnt;
      e0 = err_cnt;
      send(vec[i].pat);
      check({"valid pulses ", vec[i].pat}, vld_cnt - v0, vec[i].exp_vld);
      check({"error pulses ", vec[i].pat}, err_cnt - e0, vec[i].exp_err);
      check({"letter ", vec[i].pat}, int'(letter), vec[i].exp_letter);
    end

    // .- with a long word gap: single pulse, fixed latency from last falling edge
    v0 = vld_cnt;
    e0 = err_cnt;
    key(1'b1, 4);
    key(1'b0, 4);
    key(1'b1, 12);
    t0 = $time;
    key(1'b0, 40);
    check("A word-gap valid pulses", vld_cnt - v0, 1);
    check("A word-gap error pulses", err_cnt - e0, 0);
    check("A letter holds", int'(letter), 1);
    check("A latency cycles", int'((t_vld - t0) / 10), 11);

    // one-cycle glitch while idle
    v0 = vld_cnt;
    e0 = err_cnt;
    key(1'b1, 1);
    key(1'b0, 20);
    check("idle glitch valid", vld_cnt - v0, 0);
    check("idle glitch error", err_cnt - e0, 0);

    // S with a glitch inside each element gap
    v0 = vld_cnt;
    e0 = err_cnt;
    key(1'b1, 4); key(1'b0, 2); key(1'b1, 1); key(1'b0, 2);
    key(1'b1, 4); key(1'b0, 2); key(1'b1, 1); key(1'b0, 2);
    key(1'b1, 4); key(1'b0, 16);
    check("glitchy S valid", vld_cnt - v0, 1);
    check("glitchy S error", err_cnt - e0, 0);
    check("glitchy S letter", int'(letter), 19);

    // stuck mark
    v0 = vld_cnt;
    e0 = err_cnt;
    t0 = $time;
    key(1'b1, 40);
    check("stuck error pulses", err_cnt - e0, 1);
    check("stuck error time", int'((t_err - t0) / 10), 26);
    check("stuck letter unchanged", int'(letter), 19);
    key(1'b0, 20);
    check("stuck release error", err_cnt - e0, 1);
    check("stuck release valid", vld_cnt - v0, 0);
    send(".");
    check("recover E valid", vld_cnt - v0, 1);
    check("recover E letter", int'(letter), 5);

    // reset in the middle of O
    key(1'b1, 12);
    key(1'b0, 4);
    key(1'b1, 12);
    key(1'b0, 2);
    rst = 1'b1;
    #1;
    check("mid reset letter", int'(letter), 0);
    check("mid reset valid", int'(letter_valid), 0);
    check("mid reset error", int'(error), 0);
    v0 = vld_cnt;
    e0 = err_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    key(1'b0, 30);
    check("post reset valid", vld_cnt - v0, 0);
    check("post reset error", err_cnt - e0, 0);
    check("post reset letter", int'(letter), 0);

    check("valid and error together", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
